// File: rtl/local_mac_pkg.sv
// local_mac_pkg: shared FSM state, width derivation and sign/zero extension helpers for local_mac_bs.
package local_mac_pkg;
  typedef enum logic {IDLE, ACC} state_t;
  function automatic int acc_width(input int n_lane, input int ww, input int in_bits);
    return ww + $clog2(n_lane) + in_bits;
  endfunction
  function automatic logic [63:0] zext(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = ~64'd0 << w;
    return v & ~m;
  endfunction
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = ~64'd0 << w;
    return ((v >> (w - 1)) & 64'd1) != 64'd0 ? v | m : v & ~m;
  endfunction
endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: heap-indexed adder tree with per-op sign extension of its leaves.
// MAC_TREE_PIPE_EN inserts one register stage halfway up the tree, carrying the beat tags along.
module mac_adder_tree import local_mac_pkg::*; #(
  parameter int N_LANE = 8,
  parameter int IW = 12,
  localparam int LV = $clog2(N_LANE),
  localparam int OW = IW + LV
) (
`ifdef MAC_TREE_PIPE_EN
  input  logic                   clk,
  input  logic                   rst_n,
`endif
  input  logic                   sus,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic [N_LANE*IW-1:0]   in_data,
  output logic                   out_valid,
  output logic                   out_first,
  output logic                   out_sus,
  output logic                   pend,
  output logic [OW-1:0]          sum
);
  logic [OW-1:0] node [1:2*N_LANE-1];
  logic [OW-1:0] sums [1:N_LANE-1];
  genvar i;
  for (i = 0; i < N_LANE; i++) begin : g_leaf
    assign node[N_LANE+i] = OW'(sus ? sext(64'(in_data[i*IW +: IW]), IW) : zext(64'(in_data[i*IW +: IW]), IW));
  end
`ifdef MAC_TREE_PIPE_EN
  localparam int PD = LV - (LV + 1) / 2;
  localparam int LO = 1 << PD;
  localparam int HI = (2 << PD) - 1;
  logic [OW-1:0] mid_q [LO:HI];
  logic v_q, f_q, s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= 1'b0;
      f_q <= 1'b0;
      s_q <= 1'b0;
      for (int k = LO; k <= HI; k++) mid_q[k] <= '0;
    end else begin
      v_q <= in_valid;
      f_q <= in_first;
      s_q <= sus;
      for (int k = LO; k <= HI; k++) mid_q[k] <= sums[k];
    end
  for (i = 1; i < N_LANE; i++) begin : g_node
    assign sums[i] = node[2*i] + node[2*i+1];
    if (i >= LO && i <= HI) begin : g_r
      assign node[i] = mid_q[i];
    end else begin : g_c
      assign node[i] = sums[i];
    end
  end
  assign out_valid = v_q;
  assign out_first = f_q;
  assign out_sus   = s_q;
  assign pend      = v_q;
`else
  for (i = 1; i < N_LANE; i++) begin : g_node
    assign sums[i] = node[2*i] + node[2*i+1];
    assign node[i] = sums[i];
  end
  assign out_valid = in_valid;
  assign out_first = in_first;
  assign out_sus   = sus;
  assign pend      = 1'b0;
`endif
  assign sum = node[1];
endmodule

// File: rtl/local_mac_bs.sv
// local_mac_bs: pipelined bit-serial local MAC (OAI lanes, S1 register, adder tree, shift accumulator).
// MAC_TREE_PIPE_EN adds a register inside the adder tree (+1 cycle latency).
module local_mac_bs import local_mac_pkg::*; #(
  parameter int N_LANE = 8,
  parameter int WW = 12,
  parameter int IN_BITS = 8,
  localparam int ACC_W = acc_width(N_LANE, WW, IN_BITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sus,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic [N_LANE*WW-1:0]   wb0,
  input  logic [N_LANE*WW-1:0]   wb1,
  input  logic [N_LANE-1:0]      rwlb_row0,
  input  logic [N_LANE-1:0]      rwlb_row1,
  output logic [ACC_W-1:0]       mac_out,
  output logic                   out_valid,
  output logic                   busy
);
  localparam int TW = WW + $clog2(N_LANE);
  localparam int CW = $clog2(IN_BITS + 1);
  logic [N_LANE*WW-1:0] prod, s1_prod;
  logic op_sus, s1_valid, s1_first, s1_sus;
  logic t_valid, t_first, t_sus, t_pend;
  logic [TW-1:0] t_sum;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ACC_W-1:0] acc, acc_n, term;
  logic start, step, done;
  genvar j;
  for (j = 0; j < N_LANE; j++) begin : g_lane
    assign prod[j*WW +: WW] = ~((wb0[j*WW +: WW] | {WW{rwlb_row0[j]}}) & (wb1[j*WW +: WW] | {WW{rwlb_row1[j]}}));
  end
  // sus is only meaningful on the first beat; later beats reuse the latched op value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_sus   <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_sus   <= 1'b0;
      s1_prod  <= '0;
    end else begin
      if (in_valid && in_first) op_sus <= sus;
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_sus   <= in_first ? sus : op_sus;
      s1_prod  <= prod;
    end
  mac_adder_tree #(.N_LANE(N_LANE), .IW(WW)) u_tree (
`ifdef MAC_TREE_PIPE_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .sus       (s1_sus),
    .in_valid  (s1_valid),
    .in_first  (s1_first),
    .in_data   (s1_prod),
    .out_valid (t_valid),
    .out_first (t_first),
    .out_sus   (t_sus),
    .pend      (t_pend),
    .sum       (t_sum)
  );
  // the MSB plane of a signed activation carries negative weight
  always_comb begin
    term    = ACC_W'(t_sus ? sext(64'(t_sum), TW) : zext(64'(t_sum), TW));
    start   = t_valid & t_first;
    step    = t_valid & ~t_first & (state == ACC);
    done    = step & (cnt == CW'(IN_BITS - 1));
    state_n = start ? ACC : done ? IDLE : state;
    cnt_n   = start ? CW'(1) : done ? '0 : step ? cnt + CW'(1) : cnt;
    acc_n   = start ? (t_sus ? -term : term) : step ? (acc << 1) + term : acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mac_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      out_valid <= done;
      if (done) mac_out <= acc_n;
    end
  assign busy = (state == ACC) | s1_valid | t_pend;
endmodule

// File: tb/tb_local_mac_bs.sv
// tb_local_mac_bs: scoreboard bench for local_mac_bs; honours MAC_TREE_PIPE_EN for the expected latency.
module tb_local_mac_bs;
  localparam int N = 8, W = 12, B = 8, AW = 23;
`ifdef MAC_TREE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sus = 1'b0, in_valid = 1'b0, in_first = 1'b0;
  logic [N*W-1:0] wb0 = '0, wb1 = '0, cw0, cw1;
  logic [N-1:0] rwlb_row0 = '1, rwlb_row1 = '1, cr0, cr1;
  logic [AW-1:0] mac_out;
  logic out_valid, busy;
  int cyc = 0, checks = 0, failures = 0, pulses = 0, last_pc = 0, prev_pc = 0;
  typedef struct {longint v; int c;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  local_mac_bs dut (
    .clk(clk), .rst_n(rst_n), .sus(sus), .in_valid(in_valid), .in_first(in_first),
    .wb0(wb0), .wb1(wb1), .rwlb_row0(rwlb_row0), .rwlb_row1(rwlb_row1),
    .mac_out(mac_out), .out_valid(out_valid), .busy(busy)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      pulses++;
      prev_pc = last_pc;
      last_pc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d mac_out=%0h required=no pulse", cyc, mac_out);
      end else begin
        e = exp_q.pop_front();
        if (mac_out !== AW'(e.v) || cyc != e.c) begin
          failures++;
          $display("FAIL result got=%0h@%0d required=%0h@%0d", mac_out, cyc, AW'(e.v), e.c);
        end
      end
    end
  end

  function automatic longint lane_sum(input bit s, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                      input logic [N-1:0] r0, input logic [N-1:0] r1);
    longint t = 0;
    logic [W-1:0] p;
    for (int j = 0; j < N; j++) begin
      p = ~((a[j*W +: W] | {W{r0[j]}}) & (b[j*W +: W] | {W{r1[j]}}));
      t += s ? longint'($signed(p)) : longint'(p);
    end
    return t;
  endfunction

  task automatic do_op(input bit s, input bit rnd, input int gap_max, input int nb);
    longint e = 0, ls;
    for (int b = 0; b < nb; b++) begin
      if (b > 0 && gap_max > 0)
        repeat ($urandom_range(1, gap_max)) begin
          @(negedge clk);
          in_valid = 1'b0;
          sus = 1'($urandom);
        end
      @(negedge clk);
      if (rnd) begin
        wb0 = {$urandom, $urandom, $urandom};
        wb1 = {$urandom, $urandom, $urandom};
        rwlb_row0 = N'($urandom);
        rwlb_row1 = N'($urandom);
      end else begin
        wb0 = cw0; wb1 = cw1; rwlb_row0 = cr0; rwlb_row1 = cr1;
      end
      in_valid = 1'b1;
      in_first = (b == 0);
      sus = (b == 0) ? s : 1'($urandom);
      ls = lane_sum(s, wb0, wb1, rwlb_row0, rwlb_row1);
      e += (b == 0 && s) ? -(ls <<< (B - 1 - b)) : (ls <<< (B - 1 - b));
    end
    if (nb == B) exp_q.push_back('{e, cyc + LAT});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic set_case1();
    cw0 = {N{~12'd3}}; cw1 = {N{~12'd0}}; cr0 = '0; cr1 = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({mac_out, out_valid, busy} !== '0) begin
      failures++;
      $display("FAIL reset mac_out=%0h out_valid=%b busy=%b required=0,0,0", mac_out, out_valid, busy);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_unsigned();
    int p0 = pulses;
    set_case1();
    do_op(1'b0, 1'b0, 0, B);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_during_op got=%b required=1", busy); end
    drain();
    idle(3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_op got=%b required=0", busy); end
    checks++;
    if (mac_out !== AW'(6120) || pulses - p0 != 1) begin
      failures++;
      $display("FAIL unsigned mac_out=%0d pulses=%0d required=6120,1", mac_out, pulses - p0);
    end
  endtask

  task automatic test_signed();
    set_case1();
    do_op(1'b1, 1'b0, 0, B);
    drain();
    checks++;
    if (mac_out !== AW'(-24)) begin failures++; $display("FAIL signed mac_out=%0h required=%0h", mac_out, AW'(-24)); end
  endtask

  task automatic test_both_rows();
    cw0 = {N{~12'd1}}; cw1 = {N{~12'd2}}; cr0 = '0; cr1 = '0;
    do_op(1'b0, 1'b0, 0, B);
    drain();
    checks++;
    if (mac_out !== AW'(6120)) begin failures++; $display("FAIL both_rows mac_out=%0d required=6120", mac_out); end
  endtask

  task automatic test_stalls();
    int p0 = pulses;
    set_case1();
    do_op(1'b0, 1'b0, 5, B);
    drain();
    idle(4);
    checks++;
    if (mac_out !== AW'(6120) || pulses - p0 != 1) begin
      failures++;
      $display("FAIL stalls mac_out=%0d pulses=%0d required=6120,1", mac_out, pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    set_case1();
    do_op(1'b0, 1'b0, 0, B);
    do_op(1'b1, 1'b0, 0, B);
    drain();
    checks++;
    if (last_pc - prev_pc != 8 || pulses - p0 != 2 || mac_out !== AW'(-24)) begin
      failures++;
      $display("FAIL back_to_back spacing=%0d pulses=%0d mac_out=%0h required=8,2,%0h",
               last_pc - prev_pc, pulses - p0, mac_out, AW'(-24));
    end
  endtask

  task automatic test_idle_beat();
    int p0 = pulses;
    logic [AW-1:0] held = mac_out;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b1; in_first = 1'b0; sus = 1'b1;
    end
    idle(4);
    checks++;
    if (pulses != p0 || busy !== 1'b0 || mac_out !== held) begin
      failures++;
      $display("FAIL idle_beat pulses=%0d busy=%b mac_out=%0h required=0,0,%0h", pulses - p0, busy, mac_out, held);
    end
  endtask

  task automatic test_abort();
    int p0 = pulses;
    set_case1();
    do_op(1'b0, 1'b0, 0, 4);
    do_op(1'b1, 1'b1, 0, B);
    drain();
    idle(4);
    checks++;
    if (pulses - p0 != 1) begin failures++; $display("FAIL abort pulses=%0d required=1", pulses - p0); end
  endtask

  task automatic test_reset_mid();
    int p0 = pulses;
    set_case1();
    do_op(1'b0, 1'b0, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({mac_out, out_valid, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid mac_out=%0h out_valid=%b busy=%b required=0,0,0", mac_out, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    checks++;
    if (pulses != p0 || mac_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_pulse pulses=%0d mac_out=%0h required=0,0", pulses - p0, mac_out);
    end
  endtask

  task automatic test_random();
    int p0 = pulses;
    for (int k = 0; k < 8; k++) do_op(1'($urandom), 1'b1, (k % 2 == 0) ? 0 : 3, B);
    drain();
    checks++;
    if (pulses - p0 != 8) begin failures++; $display("FAIL random_pulses got=%0d required=8", pulses - p0); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_both_rows();
    test_stalls();
    test_back_to_back();
    test_idle_beat();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
